// File: rtl/nlp_uart_tx.sv
// ---------------------------------------------------------------------------
// nlp_uart_tx
// Memory-mapped UART transmitter with a small TX FIFO. It occupies a
// 2-word register window on the core bus.
//   BASE_ADDR+0  DATA   : write pushes wdata[7:0] into the FIFO; reads 0
//   BASE_ADDR+1  STATUS : [0] full [1] empty [2] busy [3] overflow
//                         [8:4] count; write with bit 3 set clears overflow
//
// Ports
//   i_clk      single clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_wr/i_rd  core write / read strobes
//   i_address  core address
//   i_wdata    core write data
//   o_rdata    read data (0 unless a STATUS read is in progress)
//   o_sel      high when i_address hits the register window
//   o_txd      serial output, registered, idle high
//   o_irq      one-cycle pulse when the last queued frame finishes
// ---------------------------------------------------------------------------
module nlp_uart_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr,
  input  logic        i_rd,
  input  logic [15:0] i_address,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_sel,
  output logic        o_txd,
  output logic        o_irq
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [4:0]  DEPTH_C   = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Address decode and bus side
  // -------------------------------------------------------------------------
  logic sel_data;
  logic sel_status;
  logic push_req;
  logic push_ok;
  logic pop;
  logic ovf_set;
  logic ovf_clr;

  assign sel_data   = (i_address == BASE_ADDR);
  assign sel_status = (i_address == STAT_ADDR);
  assign o_sel      = sel_data | sel_status;

  // Upper data byte is never used by the FIFO.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^i_wdata[15:8];

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [4:0]    count_reg, count_next;
  logic          ovf_reg, ovf_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    head;

  assign fifo_full  = (count_reg == DEPTH_C);
  assign fifo_empty = (count_reg == 5'd0);
  assign head       = mem[rd_ptr_reg];

  // A push into a full FIFO still succeeds when the transmitter frees a slot
  // on the same edge.
  assign push_req = i_wr & sel_data;
  assign push_ok  = push_req & (~fifo_full | pop);
  assign ovf_set  = push_req & ~push_ok;
  assign ovf_clr  = i_wr & sel_status & i_wdata[3];

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= i_wdata[7:0];
    end
  end

  // Pointer width equals log2(depth), so increments wrap naturally.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 5'd1;
      2'b01:   count_next = count_reg - 5'd1;
      default: count_next = count_reg;
    endcase
    // A rejected push on the same edge as a clear leaves the flag set.
    if (ovf_set) begin
      ovf_next = 1'b1;
    end else if (ovf_clr) begin
      ovf_next = 1'b0;
    end else begin
      ovf_next = ovf_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Transmit FSM
  // -------------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [15:0] timer_reg, timer_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic        txd_reg, txd_next;
  logic        irq_reg, irq_next;
  logic        bit_end;
  logic        busy;

  assign bit_end = (timer_reg == DIV_LAST);
  assign busy    = (state_reg != S_IDLE);

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    txd_next   = txd_reg;
    irq_next   = 1'b0;
    pop        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        txd_next = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = head;
          timer_next = 16'd0;
          txd_next   = 1'b0;
          state_next = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          timer_next = 16'd0;
          idx_next   = 3'd0;
          txd_next   = shift_reg[0];
          state_next = S_DATA;
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          timer_next = 16'd0;
          if (idx_reg == 3'd7) begin
            txd_next   = 1'b1;
            state_next = S_STOP;
          end else begin
            // The bit currently on the line is shift_reg[0]; the next one
            // is shift_reg[1], which becomes bit 0 after the shift.
            idx_next   = idx_reg + 3'd1;
            shift_next = {1'b0, shift_reg[7:1]};
            txd_next   = shift_reg[1];
          end
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          timer_next = 16'd0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit, no idle gap.
            pop        = 1'b1;
            shift_next = head;
            txd_next   = 1'b0;
            state_next = S_START;
          end else begin
            txd_next   = 1'b1;
            irq_next   = 1'b1;
            state_next = S_IDLE;
          end
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end

      default: begin
        state_next = S_IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= S_IDLE;
      timer_reg  <= 16'd0;
      idx_reg    <= 3'd0;
      shift_reg  <= 8'd0;
      txd_reg    <= 1'b1;
      irq_reg    <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= 5'd0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      txd_reg    <= txd_next;
      irq_reg    <= irq_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign o_txd = txd_reg;
  assign o_irq = irq_reg;

  // -------------------------------------------------------------------------
  // Read data: only STATUS returns anything; reads have no side effects.
  // -------------------------------------------------------------------------
  logic [15:0] status;
  assign status  = {7'd0, count_reg, ovf_reg, busy, fifo_empty, fifo_full};
  assign o_rdata = (i_rd && sel_status) ? status : 16'h0000;

endmodule
